pc_fetch_unit: RTL and testbench

- Program-counter register and next-PC selector for the MIPS CPU.
- Sits directly downstream of the branch-offset left-2 shifter and consumes its 32-bit shifted offset to form branch targets.
- Also forms jump and jr targets.
- Drives the instruction-memory fetch request with a ready handshake, stall support and wrong-path squash.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/next_pc_mux.sv | 40 ++++
 rtl/pc_fetch_unit.sv | 113 +++++++++++
 tb/tb_pc_fetch_unit.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch front end: FSM encoding, reset vector
// default and the redirect-source select used by the next-PC mux.
package cpu_pkg;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_STALL = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_3000;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_BR   = 2'd1,
    SEL_JUMP = 2'd2,
    SEL_JR   = 2'd3
  } redir_sel_e;

  function automatic logic [31:0] jump_target(input logic [31:0] pc4,
                                              input logic [25:0] idx);
    return {pc4[31:28], idx, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_mux.sv
// Redirect target formation with jr > jump > branch priority.
// Purely combinational; the fetch unit decides when the target is used.
module next_pc_mux
  import cpu_pkg::*;
(
  input  logic [31:0] redir_pc4,
  input  logic        br_taken,
  input  logic [31:0] br_off_sh,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic [31:0] target,
  output logic        redirect,
  output logic        jr_misaligned
);

  redir_sel_e sel;

  always_comb begin
    sel = SEL_NONE;
    if (jr)            sel = SEL_JR;
    else if (jump)     sel = SEL_JUMP;
    else if (br_taken) sel = SEL_BR;
  end

  always_comb begin
    target = '0;
    case (sel)
      SEL_JR:   target = {jr_target[31:2], 2'b00};
      SEL_JUMP: target = jump_target(redir_pc4, jump_index);
      SEL_BR:   target = redir_pc4 + br_off_sh;
      default:  target = '0;
    endcase
  end

  assign redirect      = (sel != SEL_NONE);
  assign jr_misaligned = jr && (jr_target[1:0] != 2'b00);

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and fetch FSM: drives the imem request, records pending
// redirects while the memory is busy and squashes wrong-path fetches.
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        imem_ready,
  input  logic [31:0] redir_pc4,
  input  logic        br_taken,
  input  logic [31:0] br_off_sh,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid,
  output logic [31:0] fetch_pc,
  output logic        addr_err
);

  fetch_state_e state_q;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pend_target_q;
  logic         pend_valid_q;
  logic         fetch_valid_q;
  logic [31:0]  fetch_pc_q;
  logic         addr_err_q;

  logic [31:0]  target;
  logic         redirect;
  logic         jr_misaligned;
  logic         accept;
  logic         wrong_path;

  next_pc_mux u_mux (
    .redir_pc4     (redir_pc4),
    .br_taken      (br_taken),
    .br_off_sh     (br_off_sh),
    .jump          (jump),
    .jump_index    (jump_index),
    .jr            (jr),
    .jr_target     (jr_target),
    .target        (target),
    .redirect      (redirect),
    .jr_misaligned (jr_misaligned)
  );

  assign pc_plus4   = pc_q + 32'd4;
  assign accept     = (state_q == S_FETCH) && imem_ready;
  assign wrong_path = redirect || pend_valid_q;

  // A redirect on the accept cycle beats an older pending one (newest wins).
  always_comb begin
    pc_d = pc_plus4;
    if (redirect)          pc_d = target;
    else if (pend_valid_q) pc_d = pend_target_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_BOOT;
      pc_q          <= RESET_VECTOR;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
      fetch_valid_q <= 1'b0;
      fetch_pc_q    <= '0;
      addr_err_q    <= 1'b0;
    end else begin
      fetch_valid_q <= 1'b0;
      if (jr_misaligned) addr_err_q <= 1'b1;
      case (state_q)
        S_BOOT: state_q <= S_FETCH;
        S_FETCH: begin
          if (accept) begin
            pc_q         <= pc_d;
            pend_valid_q <= 1'b0;
            if (!wrong_path) begin
              fetch_valid_q <= 1'b1;
              fetch_pc_q    <= pc_q;
            end
            state_q <= stall ? S_STALL : S_FETCH;
          end else if (redirect) begin
            pend_valid_q  <= 1'b1;
            pend_target_q <= target;
          end
        end
        S_STALL: begin
          if (redirect) begin
            pc_q         <= target;
            pend_valid_q <= 1'b0;
          end
          if (!stall) state_q <= S_FETCH;
        end
        default: state_q <= S_BOOT;
      endcase
    end
  end

  assign imem_req    = (state_q == S_FETCH);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign fetch_valid = fetch_valid_q;
  assign fetch_pc    = fetch_pc_q;
  assign addr_err    = addr_err_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: directed scenarios then random traffic,
// checked against a transaction-level model of the fetch rules.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n, stall, imem_ready, br_taken, jump, jr;
  logic [31:0] redir_pc4, br_off_sh, jr_target;
  logic [25:0] jump_index;

  logic        imem_req, fetch_valid, addr_err;
  logic [31:0] imem_addr, pc, pc_plus4, fetch_pc;
  logic        w_req, w_fv, w_err;
  logic [31:0] w_addr, w_pc, w_pc4, w_fpc;

  always #5 clk = ~clk;

  pc_fetch_unit u_dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .imem_ready(imem_ready),
    .redir_pc4(redir_pc4), .br_taken(br_taken), .br_off_sh(br_off_sh),
    .jump(jump), .jump_index(jump_index), .jr(jr), .jr_target(jr_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .pc(pc), .pc_plus4(pc_plus4),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .addr_err(addr_err)
  );

  // Second instance exercises the PC wrap from the top of the address space.
  pc_fetch_unit #(.RESET_VECTOR(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst_n(rst_n), .stall(1'b0), .imem_ready(1'b1),
    .redir_pc4(32'h0), .br_taken(1'b0), .br_off_sh(32'h0),
    .jump(1'b0), .jump_index(26'h0), .jr(1'b0), .jr_target(32'h0),
    .imem_req(w_req), .imem_addr(w_addr), .pc(w_pc), .pc_plus4(w_pc4),
    .fetch_valid(w_fv), .fetch_pc(w_fpc), .addr_err(w_err)
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  // Model state: what the fetch front end should look like between edges.
  bit          m_boot, m_stalled, m_pend, m_err;
  logic [31:0] m_pc, m_ptgt;

  function automatic void chk(input string nm, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endfunction

  function automatic void model_step();
    logic [31:0] tgt;
    bit          redir;
    if (!rst_n) begin
      m_pc = 32'h0000_3000; m_boot = 1; m_stalled = 0;
      m_pend = 0; m_ptgt = 0; m_err = 0;
      return;
    end
    redir = jr || jump || br_taken;
    if (jr)            tgt = jr_target & 32'hFFFF_FFFC;
    else if (jump)     tgt = (redir_pc4 & 32'hF000_0000) | ({6'b0, jump_index} * 4);
    else               tgt = redir_pc4 + br_off_sh;
    if (jr && (jr_target % 4 != 0)) m_err = 1;
    if (m_boot) begin
      m_boot = 0;
    end else if (!m_stalled) begin
      if (imem_ready) begin
        if (!redir && !m_pend) exp_q.push_back(m_pc);
        m_pc = redir ? tgt : (m_pend ? m_ptgt : m_pc + 4);
        m_pend = 0;
        m_stalled = stall;
      end else if (redir) begin
        m_pend = 1; m_ptgt = tgt;
      end
    end else begin
      if (redir) begin m_pc = tgt; m_pend = 0; end
      if (!stall) m_stalled = 0;
    end
  endfunction

  task automatic idle();
    rst_n = 1'b1; stall = 1'b0; imem_ready = 1'b1;
    br_taken = 1'b0; jump = 1'b0; jr = 1'b0;
    redir_pc4 = 32'h0; br_off_sh = 32'h0; jr_target = 32'h0; jump_index = 26'h0;
  endtask

  task automatic step();
    model_step();
    @(negedge clk);
    chk("imem_req", 32'(imem_req), 32'(!m_boot && !m_stalled));
    chk("imem_addr", imem_addr, m_pc);
    chk("pc", pc, m_pc);
    chk("pc_plus4", pc_plus4, m_pc + 32'd4);
    chk("addr_err", 32'(addr_err), 32'(m_err));
  endtask

  // Monitor: every fetch_valid pulse must match the oldest predicted fetch.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (fetch_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL fetch_valid_unexpected actual_pc=%h expected=no_pulse", fetch_pc);
        end else begin
          e = exp_q.pop_front();
          chk("fetch_pc", fetch_pc, e);
        end
      end
    end
  end

  initial begin
    idle();
    @(negedge clk);
    rst_n = 1'b0; step(); rst_n = 1'b0; step();
    chk("rst_fetch_pc", fetch_pc, 32'h0);
    chk("rst_fetch_valid", 32'(fetch_valid), 32'h0);
    chk("rst_pc", pc, 32'h0000_3000);
    chk("rst_wrap_pc", w_pc, 32'hFFFF_FFFC);

    idle(); step();
    chk("boot_addr", imem_addr, 32'h3000);
    chk("boot_req", 32'(imem_req), 32'h1);
    idle(); step();
    chk("seq_addr1", imem_addr, 32'h3004);
    chk("wrap_addr", w_addr, 32'h0);
    chk("wrap_valid_pc", w_fpc, 32'hFFFF_FFFC);
    idle(); step();
    chk("seq_addr2", imem_addr, 32'h3008);

    idle(); br_taken = 1'b1; redir_pc4 = 32'h3008; br_off_sh = 32'hFFFF_FFF8; step();
    chk("branch_addr", imem_addr, 32'h3000);
    chk("branch_squash", 32'(fetch_valid), 32'h0);

    for (int i = 0; i < 3; i++) begin idle(); step(); end
    chk("pre_jump_addr", imem_addr, 32'h300C);
    idle(); imem_ready = 1'b0; jump = 1'b1; redir_pc4 = 32'h3010; jump_index = 26'h0000C40; step();
    idle(); imem_ready = 1'b0; step();
    idle(); imem_ready = 1'b0; step();
    chk("jump_hold_addr", imem_addr, 32'h300C);
    idle(); step();
    chk("jump_addr", imem_addr, 32'h3100);
    chk("jump_squash", 32'(fetch_valid), 32'h0);

    idle(); br_taken = 1'b1; jump = 1'b1; jr = 1'b1; jr_target = 32'h4002;
    redir_pc4 = 32'h3104; br_off_sh = 32'h40; jump_index = 26'h123; step();
    chk("prio_pc", pc, 32'h4000);
    chk("addr_err_set", 32'(addr_err), 32'h1);
    idle(); step();
    chk("addr_err_sticky", 32'(addr_err), 32'h1);

    idle(); stall = 1'b1; step();
    chk("stall_req", 32'(imem_req), 32'h0);
    idle(); stall = 1'b1; jr = 1'b1; jr_target = 32'h5000; step();
    chk("stall_jr_req", 32'(imem_req), 32'h0);
    idle(); step();
    chk("unstall_req", 32'(imem_req), 32'h1);
    chk("unstall_addr", imem_addr, 32'h5000);

    idle(); imem_ready = 1'b0; step();
    idle(); rst_n = 1'b0; step();
    chk("midrst_req", 32'(imem_req), 32'h0);
    chk("midrst_pc", pc, 32'h3000);
    chk("midrst_wrap_pc", w_pc, 32'hFFFF_FFFC);

    for (int i = 0; i < 3000; i++) begin
      idle();
      rst_n      = ($urandom_range(0, 99) != 0);
      stall      = ($urandom_range(0, 4) == 0);
      imem_ready = ($urandom_range(0, 9) < 7);
      br_taken   = ($urandom_range(0, 6) == 0);
      jump       = ($urandom_range(0, 9) == 0);
      jr         = ($urandom_range(0, 11) == 0);
      redir_pc4  = $urandom() & 32'hFFFF_FFFC;
      br_off_sh  = $urandom() & 32'hFFFF_FFFC;
      jump_index = 26'($urandom());
      jr_target  = $urandom();
      if ($urandom_range(0, 3) != 0) jr_target[1:0] = 2'b00;
      step();
    end

    idle(); imem_ready = 1'b0; step();
    idle(); imem_ready = 1'b0; step();
    chk("scoreboard_drain", exp_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
